// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: holds the fetch PC, issues single-outstanding imem
// requests and hands instructions to decode. Optional: FETCH_ALIGN_CHECK_EN.
module fetch_pc_ctrl #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              STEP     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_redirect_valid,
    input  logic [PC_W-1:0] i_redirect_target,
    input  logic            i_stall,
    output logic            o_imem_req_valid,
    output logic [PC_W-1:0] o_imem_req_addr,
    input  logic            i_imem_req_ready,
    input  logic            i_imem_rsp_valid,
    input  logic [31:0]     i_imem_rsp_data,
    output logic            o_inst_valid,
    output logic [PC_W-1:0] o_inst_pc,
    output logic [31:0]     o_inst_data,
    input  logic            i_inst_ready,
    output logic            o_misalign_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_seq;
    logic [PC_W-1:0] w_target;
    logic            r_drop;
    logic            w_drop_nxt;
    logic            w_redir;
    logic            w_load_inst;
    logic [PC_W-1:0] r_inst_pc;
    logic [31:0]     r_inst_data;

`ifdef FETCH_ALIGN_CHECK_EN
    logic w_misalign;
    logic r_misalign;

    // A misaligned target is refused outright and only reported.
    assign w_misalign = i_redirect_valid &&
                        (i_redirect_target[1:0] != 2'b00);
    assign w_redir    = i_redirect_valid && !w_misalign;
    assign w_target   = i_redirect_target;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
        end
    end

    assign o_misalign_err = r_misalign;
`else
    logic w_unused_lsb;

    assign w_unused_lsb   = ^i_redirect_target[1:0];
    assign w_redir        = i_redirect_valid;
    assign w_target       = {i_redirect_target[PC_W-1:2], 2'b00};
    assign o_misalign_err = 1'b0;
`endif

    assign w_pc_seq = r_pc + PC_W'(STEP);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_load_inst = 1'b0;
        if (w_redir) begin
            w_pc_nxt = w_target;
        end
        unique case (r_state)
            S_IDLE: begin
                if (!i_stall) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (i_imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                    // Old request already accepted: its response is stale.
                    if (w_redir) begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (i_imem_rsp_valid) begin
                    if (r_drop || w_redir) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_load_inst = 1'b1;
                        w_pc_nxt    = w_pc_seq;
                        w_state_nxt = S_OUT;
                    end
                end else if (w_redir) begin
                    w_drop_nxt = 1'b1;
                end
            end
            S_OUT: begin
                if (w_redir) begin
                    w_state_nxt = S_IDLE;
                end else if (i_inst_ready) begin
                    w_state_nxt = i_stall ? S_IDLE : S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_inst_pc   <= '0;
            r_inst_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            if (w_load_inst) begin
                r_inst_pc   <= r_pc;
                r_inst_data <= i_imem_rsp_data;
            end
        end
    end

    assign o_imem_req_valid = (r_state == S_REQ);
    assign o_imem_req_addr  = r_pc;
    assign o_inst_valid     = (r_state == S_OUT);
    assign o_inst_pc        = r_inst_pc;
    assign o_inst_data      = r_inst_data;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: free-run table plus redirect,
// stall, wrap and reset corner sequences.
module tb_fetch_pc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_ready;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        misalign;

    logic        req_valid2;
    logic [31:0] req_addr2;
    logic        inst_valid2;
    logic [31:0] inst_pc2;
    logic [31:0] inst_data2;
    logic        misalign2;

    int n_checks;
    int n_errors;

    logic        auto_mem;
    logic        acc;
    logic [31:0] acc_addr;

    fetch_pc_ctrl u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_stall           (stall),
        .o_imem_req_valid  (req_valid),
        .o_imem_req_addr   (req_addr),
        .i_imem_req_ready  (req_ready),
        .i_imem_rsp_valid  (rsp_valid),
        .i_imem_rsp_data   (rsp_data),
        .o_inst_valid      (inst_valid),
        .o_inst_pc         (inst_pc),
        .o_inst_data       (inst_data),
        .i_inst_ready      (inst_ready),
        .o_misalign_err    (misalign)
    );

    fetch_pc_ctrl #(
        .PC_W     (32),
        .RESET_PC (32'hFFFF_FFF8),
        .STEP     (4)
    ) u_dut_wrap (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_stall           (stall),
        .o_imem_req_valid  (req_valid2),
        .o_imem_req_addr   (req_addr2),
        .i_imem_req_ready  (req_ready),
        .i_imem_rsp_valid  (rsp_valid),
        .i_imem_rsp_data   (rsp_data),
        .o_inst_valid      (inst_valid2),
        .o_inst_pc         (inst_pc2),
        .o_inst_data       (inst_data2),
        .i_inst_ready      (inst_ready),
        .o_misalign_err    (misalign2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rdy;
        logic        irdy;
        logic        req_v;
        logic [31:0] addr;
        logic        inst_v;
        logic [31:0] ipc;
        logic [31:0] addr2;
        logic [31:0] ipc2;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic vec_t mk(
        input logic        rv,
        input logic [31:0] ad,
        input logic        iv,
        input logic [31:0] pc,
        input logic [31:0] ad2,
        input logic [31:0] pc2
    );
        vec_t v;
        v.stall  = 1'b0;
        v.rdy    = 1'b1;
        v.irdy   = 1'b1;
        v.req_v  = rv;
        v.addr   = ad;
        v.inst_v = iv;
        v.ipc    = pc;
        v.addr2  = ad2;
        v.ipc2   = pc2;
        return v;
    endfunction

    task automatic chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One clock: mem model samples acceptance mid-cycle, replies next cycle.
    task automatic cyc();
        @(negedge clk);
        acc      = req_valid && req_ready;
        acc_addr = req_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            rsp_valid = acc;
            rsp_data  = mem(acc_addr);
        end
    endtask

    task automatic do_reset();
        auto_mem       = 1'b0;
        rsp_valid      = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    logic [31:0] exp_c;
    logic [31:0] exp_m;

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        auto_mem        = 1'b0;
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        stall           = 1'b0;
        req_ready       = 1'b1;
        rsp_valid       = 1'b0;
        rsp_data        = '0;
        inst_ready      = 1'b1;

        tbl[0] = mk(1'b1, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h0);
        tbl[1] = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h0);
        tbl[2] = mk(1'b0, 32'h4, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8);
        tbl[3] = mk(1'b1, 32'h4, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0);
        tbl[4] = mk(1'b0, 32'h4, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0);
        tbl[5] = mk(1'b0, 32'h8, 1'b1, 32'h4, 32'h0000_0000, 32'hFFFF_FFFC);
        tbl[6] = mk(1'b1, 32'h8, 1'b0, 32'h0, 32'h0000_0000, 32'h0);
        tbl[7] = mk(1'b0, 32'h8, 1'b0, 32'h0, 32'h0000_0000, 32'h0);
        tbl[8] = mk(1'b0, 32'hC, 1'b1, 32'h8, 32'h0000_0004, 32'h0);

        // Reset state
        cyc();
        cyc();
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_addr", req_addr, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_addr_wrap", req_addr2, 32'hFFFF_FFF8);
        rst_n    = 1'b1;
        auto_mem = 1'b1;

        // Free-run table, both instances share stimulus
        for (int i = 0; i < 9; i++) begin
            stall      = tbl[i].stall;
            req_ready  = tbl[i].rdy;
            inst_ready = tbl[i].irdy;
            cyc();
            chk($sformatf("run%0d_req_v", i), {31'd0, req_valid},
                {31'd0, tbl[i].req_v});
            chk($sformatf("run%0d_addr", i), req_addr, tbl[i].addr);
            chk($sformatf("run%0d_inst_v", i), {31'd0, inst_valid},
                {31'd0, tbl[i].inst_v});
            chk($sformatf("run%0d_addr2", i), req_addr2, tbl[i].addr2);
            chk($sformatf("run%0d_req_v2", i), {31'd0, req_valid2},
                {31'd0, tbl[i].req_v});
            chk($sformatf("run%0d_mis", i), {30'd0, misalign, misalign2},
                32'd0);
            if (tbl[i].inst_v) begin
                chk($sformatf("run%0d_ipc", i), inst_pc, tbl[i].ipc);
                chk($sformatf("run%0d_data", i), inst_data, mem(tbl[i].ipc));
                chk($sformatf("run%0d_inst_v2", i), {31'd0, inst_valid2},
                    32'd1);
                chk($sformatf("run%0d_ipc2", i), inst_pc2, tbl[i].ipc2);
                chk($sformatf("run%0d_data2", i), inst_data2,
                    mem(tbl[i].ipc));
            end
        end

        // Redirect in S_WAIT: late DEADBEEF must be discarded
        do_reset();
        stall      = 1'b0;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        cyc();
        cyc();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        cyc();
        redirect_valid = 1'b0;
        chk("wait_redir_addr", req_addr, 32'h100);
        chk("wait_redir_req_v", {31'd0, req_valid}, 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD_BEEF;
        cyc();
        rsp_valid = 1'b0;
        chk("wait_drop_inst_v", {31'd0, inst_valid}, 32'd0);
        cyc();
        chk("wait_next_req_v", {31'd0, req_valid}, 32'd1);
        chk("wait_next_addr", req_addr, 32'h100);
        cyc();
        rsp_valid = 1'b1;
        rsp_data  = 32'h1111_1111;
        cyc();
        rsp_valid = 1'b0;
        chk("wait_fetch_inst_v", {31'd0, inst_valid}, 32'd1);
        chk("wait_fetch_pc", inst_pc, 32'h100);
        chk("wait_fetch_data", inst_data, 32'h1111_1111);

        // Redirect in S_REQ without ready: request retargets, valid held
        do_reset();
        req_ready = 1'b0;
        cyc();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0040;
        cyc();
        redirect_valid = 1'b0;
        chk("req_redir_v", {31'd0, req_valid}, 32'd1);
        chk("req_redir_addr", req_addr, 32'h40);
        cyc();
        chk("req_hold_v", {31'd0, req_valid}, 32'd1);
        chk("req_hold_addr", req_addr, 32'h40);
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h2222_2222;
        cyc();
        rsp_valid = 1'b0;
        chk("req_fetch_inst_v", {31'd0, inst_valid}, 32'd1);
        chk("req_fetch_pc", inst_pc, 32'h40);
        chk("req_fetch_data", inst_data, 32'h2222_2222);

        // Misaligned target from S_IDLE
        do_reset();
        stall = 1'b1;
        cyc();
        stall           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0022;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_c = 32'h0;
        exp_m = 32'd1;
`else
        exp_c = 32'h20;
        exp_m = 32'd0;
`endif
        cyc();
        redirect_valid = 1'b0;
        chk("mis_req_v", {31'd0, req_valid}, 32'd1);
        chk("mis_addr", req_addr, exp_c);
        chk("mis_err", {31'd0, misalign}, exp_m);
        cyc();
        chk("mis_err_clear", {31'd0, misalign}, 32'd0);
        chk("mis_addr_hold", req_addr, exp_c);

        // Stall with decode back-pressure in S_OUT at 0x10
        do_reset();
        stall           = 1'b1;
        req_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0010;
        cyc();
        redirect_valid = 1'b0;
        chk("idle_load_addr", req_addr, 32'h10);
        chk("idle_stall_req_v", {31'd0, req_valid}, 32'd0);
        stall = 1'b0;
        cyc();
        cyc();
        rsp_valid  = 1'b1;
        rsp_data   = 32'h3333_3333;
        inst_ready = 1'b0;
        stall      = 1'b1;
        cyc();
        rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_hold%0d_v", k), {31'd0, inst_valid}, 32'd1);
            chk($sformatf("out_hold%0d_pc", k), inst_pc, 32'h10);
            chk($sformatf("out_hold%0d_data", k), inst_data, 32'h3333_3333);
            cyc();
        end
        inst_ready = 1'b1;
        cyc();
        chk("out_rel_inst_v", {31'd0, inst_valid}, 32'd0);
        chk("out_rel_req_v", {31'd0, req_valid}, 32'd0);
        cyc();
        chk("stall_idle_req_v", {31'd0, req_valid}, 32'd0);
        stall     = 1'b0;
        req_ready = 1'b0;
        cyc();
        chk("unstall_req_v", {31'd0, req_valid}, 32'd1);
        chk("unstall_addr", req_addr, 32'h14);

        // Reset in S_WAIT, stale response afterwards ignored
        req_ready = 1'b1;
        cyc();
        chk("rstw_in_wait", {30'd0, req_valid, inst_valid}, 32'd0);
        rst_n = 1'b0;
        cyc();
        chk("rstw_addr", req_addr, 32'h0);
        chk("rstw_v", {30'd0, req_valid, inst_valid}, 32'd0);
        rst_n     = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 32'h4444_4444;
        cyc();
        rsp_valid = 1'b0;
        chk("rstw_stale_inst_v", {31'd0, inst_valid}, 32'd0);
        chk("rstw_req_v", {31'd0, req_valid}, 32'd1);
        chk("rstw_req_addr", req_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
